// File: rtl/truth_table_scanner.sv
// Steps a 3-bit select through minterms 0..7, waits SETTLE_CYCLES at each, and captures f_in into an 8-bit truth table.
// Optional feature: define SCAN_COMPARE_EN to add the expected/match reference comparison.
module truth_table_scanner #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic [2:0] sel_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out
`ifdef SCAN_COMPARE_EN
    ,
    input  logic [7:0] expected,
    output logic       match
`endif
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("truth_table_scanner: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [7:0]  shadow_reg, shadow_next;
    logic [7:0]  table_reg, table_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic        sample_hit;
    logic        accept;
    logic        done_entry;
    logic [7:0]  sampled_table;

    assign sample_hit = (state_reg == SETTLE) && (cnt_reg == CNT_LAST);
    assign accept     = (state_reg == IDLE) && start;
    assign done_entry = sample_hit && (idx_reg == 3'd7);

    // Shadow with the current minterm's bit replaced, so the final load includes the last sample.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sample
            assign sampled_table[gi] = (sample_hit && (idx_reg == 3'(gi))) ? f_in : shadow_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        shadow_next = shadow_reg;
        table_next  = table_reg;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = SETTLE;
                    idx_next    = 3'd0;
                    cnt_next    = 4'd0;
                    shadow_next = 8'h00;
                    busy_next   = 1'b1;
                end
            end
            SETTLE: begin
                busy_next = 1'b1;
                if (sample_hit) begin
                    shadow_next = sampled_table;
                    cnt_next    = 4'd0;
                    if (idx_reg == 3'd7) begin
                        table_next = sampled_table;
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                // sel_out must read 0 again in IDLE
                state_next = IDLE;
                idx_next   = 3'd0;
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= 3'd0;
            cnt_reg    <= 4'd0;
            shadow_reg <= 8'h00;
            table_reg  <= 8'h00;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            shadow_reg <= shadow_next;
            table_reg  <= table_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign sel_out   = idx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign table_out = table_reg;

`ifdef SCAN_COMPARE_EN
    logic [7:0] expected_reg;
    logic       match_reg;

    // expected is frozen at start so mid-scan changes cannot affect the verdict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            expected_reg <= 8'h00;
            match_reg    <= 1'b0;
        end else begin
            if (accept) begin
                expected_reg <= expected;
            end
            if (done_entry) begin
                match_reg <= (sampled_table == expected_reg);
            end
        end
    end

    assign match = match_reg;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized bench for truth_table_scanner: two instances (SETTLE_CYCLES 1 and 3) checked every cycle against a timing-formula reference model.
module tb_truth_table_scanner;

    localparam int NI = 2;
    localparam int S_OF [NI] = '{1, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] func_v = 8'h00;
    logic [7:0] expected_v = 8'h00;

    logic       f_in    [NI];
    logic [2:0] sel     [NI];
    logic       busy    [NI];
    logic       done    [NI];
    logic [7:0] tbl     [NI];
`ifdef SCAN_COMPARE_EN
    logic       match_w [NI];
`endif

    // The downstream "mux": f_in is a combinational lookup of the current select.
    assign f_in[0] = func_v[sel[0]];
    assign f_in[1] = func_v[sel[1]];

    truth_table_scanner #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .f_in      (f_in[0]),
        .sel_out   (sel[0]),
        .busy      (busy[0]),
        .done      (done[0]),
        .table_out (tbl[0])
`ifdef SCAN_COMPARE_EN
        ,
        .expected  (expected_v),
        .match     (match_w[0])
`endif
    );

    truth_table_scanner #(.SETTLE_CYCLES(3)) u_dut_s3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .f_in      (f_in[1]),
        .sel_out   (sel[1]),
        .busy      (busy[1]),
        .done      (done[1]),
        .table_out (tbl[1])
`ifdef SCAN_COMPARE_EN
        ,
        .expected  (expected_v),
        .match     (match_w[1])
`endif
    );

    // Reference model: phase = edges since start was accepted, -1 when idle.
    int         phase    [NI] = '{-1, -1};
    logic [7:0] shadow_m [NI] = '{8'h00, 8'h00};
    logic [7:0] table_m  [NI] = '{8'h00, 8'h00};
    logic [7:0] exp_m    [NI] = '{8'h00, 8'h00};
    logic       match_m  [NI] = '{1'b0, 1'b0};

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input int inst, input logic [7:0] got, input logic [7:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s (S=%0d) t=%0t got=0x%02h want=0x%02h", tag, S_OF[inst], $time, got, want);
        end
    endtask

    task automatic model_edge(input int i);
        int s;
        int m;
        int k;
        s = S_OF[i];
        m = phase[i];
        if (!rst_n) begin
            phase[i]    = -1;
            shadow_m[i] = 8'h00;
            table_m[i]  = 8'h00;
            match_m[i]  = 1'b0;
        end else if (m < 0) begin
            if (start) begin
                phase[i]    = 0;
                shadow_m[i] = 8'h00;
                exp_m[i]    = expected_v;
            end
        end else if (m < 8 * s) begin
            // Minterm k is sampled at the (k+1)*S-th edge after the accept edge.
            if (((m + 1) % s) == 0) begin
                k = (m + 1) / s - 1;
                shadow_m[i][k] = func_v[k];
            end
            if (m + 1 == 8 * s) begin
                table_m[i] = shadow_m[i];
                match_m[i] = (shadow_m[i] == exp_m[i]);
            end
            phase[i] = m + 1;
        end else begin
            phase[i] = -1;
        end
    endtask

    task automatic check_outputs(input int i);
        int s;
        int p;
        logic [2:0] e_sel;
        logic e_busy;
        logic e_done;
        s = S_OF[i];
        p = phase[i];
        if (p < 0) begin
            e_sel = 3'd0; e_busy = 1'b0; e_done = 1'b0;
        end else if (p < 8 * s) begin
            e_sel = 3'(p / s); e_busy = 1'b1; e_done = 1'b0;
        end else begin
            e_sel = 3'd7; e_busy = 1'b1; e_done = 1'b1;
        end
        check("sel_out", i, {5'd0, sel[i]}, {5'd0, e_sel});
        check("busy", i, {7'd0, busy[i]}, {7'd0, e_busy});
        check("done", i, {7'd0, done[i]}, {7'd0, e_done});
        check("table_out", i, tbl[i], table_m[i]);
`ifdef SCAN_COMPARE_EN
        check("match", i, {7'd0, match_w[i]}, {7'd0, match_m[i]});
`endif
    endtask

    task automatic step(input logic rn, input logic st);
        rst_n = rn;
        start = st;
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_edge(i);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_outputs(i);
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) step(1'b1, 1'b0);
    endtask

    task automatic check_tables(input string tag, input logic [7:0] want);
        for (int i = 0; i < NI; i++) check(tag, i, tbl[i], want);
    endtask

    initial begin
        // Reset held with start high: nothing may begin.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_tables("reset_table", 8'h00);

        // Minterms 1,4,7; expected changes mid-scan without effect.
        func_v = 8'h92;
        expected_v = 8'h92;
        step(1'b1, 1'b1);
        idle_cycles(4);
        expected_v = 8'h00;
        idle_cycles(30);
        check_tables("table_m147", 8'h92);

        // Same function against a wrong reference.
        expected_v = 8'h93;
        step(1'b1, 1'b1);
        idle_cycles(30);
        check_tables("table_m147_rerun", 8'h92);

        // f_in = sel_out[0], with start pulses sprinkled through the scan.
        func_v = 8'hAA;
        step(1'b1, 1'b1);
        for (int c = 0; c < 20; c++) step(1'b1, (c % 4) == 1);
        idle_cycles(30);
        check_tables("table_sel0", 8'hAA);

        // Reset in the middle of a scan that would otherwise rewrite the table.
        func_v = 8'h0F;
        step(1'b1, 1'b1);
        idle_cycles(4);
        step(1'b0, 1'b0);
        check_tables("table_after_midreset", 8'h00);
        func_v = 8'hFF;
        step(1'b1, 1'b1);
        idle_cycles(30);
        check_tables("table_all_ones", 8'hFF);

        // start held high: back-to-back scans with one IDLE cycle between.
        func_v = 8'h00;
        for (int c = 0; c < 60; c++) step(1'b1, 1'b1);
        idle_cycles(30);
        check_tables("table_all_zero", 8'h00);

        // Random traffic: functions and references change at any time, rare resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) func_v = 8'($urandom);
            expected_v = ($urandom_range(0, 1) == 0) ? func_v : 8'($urandom);
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
